seg7_scan: RTL and testbench
============================

# seg7_scan

Parametrised, multiplexed N-digit 7-segment scan driver; successor to the fixed four-digit display driver. Takes a hex word or raw pixel pattern from the display mux and scans it onto common-anode digits. Adds a runtime digit count, per-digit decimal points, leading-zero blanking, 16-step brightness PWM, tear-free frame latching and a frame-done strobe. Sits between the board display mux and the SEG/AN pins; the board top applies any pin inversion.

## Interface
- `DIGITS`, 4: number of digits scanned, 1..8.
- `SUB_DIV`, 16: clocks per brightness phase, ≥2. One digit slot is 16·SUB_DIV clocks.
- `clk` in 1: scan clock, 1 MHz on the boards.
- `reset` in 1: synchronous, active-high.
- `di` in 4·DIGITS: hex nibbles; nibble i drives digit i, and digit 0 is rightmost.
- `pixels` in 8·DIGITS: raw segment bytes for direct mode, byte i → digit i.
- `direct` in 1: 1 selects pixel mode, 0 selects hex mode.
- `dp` in DIGITS: decimal point per digit, hex mode only.
- `blank_lz` in 1: enables leading-zero blanking in hex mode.
- `bright` in 4: duty level 0..15; active phases per slot = bright+1.
- `seg` out 8: active-high; bit0=a … bit6=g, bit7=dp.
- `an` out DIGITS: active-high digit enable, one-hot or all-zero.
- `frame` out 1: one-clock pulse when the last digit slot ends.

## Operation
- Counters:
  - `sub` counts 0..SUB_DIV-1.
  - `phase` steps 0..15 when `sub` wraps.
  - `idx` steps 0..DIGITS-1 when `phase` wraps.
  - `idx` wraps DIGITS-1→0.
  - A "tick" is the cycle where `sub`=SUB_DIV-1 and `phase`=15.
- Shadow registers for `di`, `pixels`, `dp`, `direct` and `blank_lz` load together:
  - on the tick that wraps `idx` to 0;
  - on the first cycle after reset deasserts, via a load-pending flag set during reset.
  - Input changes mid-frame are never visible. `bright` is not shadowed and takes effect on the next phase compare.
- Hex mode:
  - `seg[6:0]` = font(nibble), standard 0-9, A, b, C, d, E, F.
  - `seg[7]` = `dp[idx]`.
- Leading-zero blanking, hex mode with `blank_lz`=1:
  - Digit i>0 is blanked (`seg[6:0]`=0) when its nibble and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - `dp` is still shown on a blanked digit.
- Direct mode: `seg` = `pixels[8·idx +: 8]`; `dp` and `blank_lz` are ignored.
- `an[idx]`=1 only when `phase` ≤ `bright` and the cycle is not the ghost-guard cycle (`phase`=0, `sub`=0). All other bits of `an` are 0.
- `frame` is 1 in the cycle after the tick that wraps `idx` to 0.

## Timing
- All outputs are registered. `seg` and `an` reflect the counter state of the previous cycle, so there is 1 clock latency from counter to pins.
- After reset the outputs are: `seg`=0, `an`=0, `frame`=0. Counters are 0. Shadows are 0 until the post-reset load.
- First lit output appears 2 cycles after reset deasserts:
  - cycle 1: shadow load plus the ghost-guard cycle;
  - cycle 2: `an[0]`=1.
- Digit slot = 16·SUB_DIV clocks. Frame = DIGITS·16·SUB_DIV clocks.
- Ghost guard: `an`=0 for exactly 1 clock at the start of every slot. `seg` switches to the new digit in that same cycle.
- Reset asserted mid-frame: the next cycle shows `an`=0 and `seg`=0, and the scan restarts at digit 0.
- Shadow load and `frame` occur in the same cycle as the wrap to 0.
- DIGITS=1: `idx` stays 0; `frame` pulses every 16·SUB_DIV clocks.

## Structure
- Package `seg7_pkg`:
  - segment bit-position constants;
  - the 16-entry hex font constant;
  - the phase count of 16.
- Sub-module `seg7_font`: combinational nibble → 7-bit pattern lookup.
- The top body holds the counters, shadows, blanking chain and output registers.

## Test plan
- Hex scan: DIGITS=4, SUB_DIV=2, `di`=16'h12AF, `bright`=15, `blank_lz`=0.
  - Slot 0 gives `seg`=0x71 (F); slot 3 gives 0x06 (1).
  - `an` walks 0001→0010→0100→1000.
  - `frame` fires every 128 clocks.
- Blanking: `di`=16'h0040, `blank_lz`=1, `dp`=4'b1000.
  - Digit 3 gives `seg`=0x80.
  - Digit 2 gives 0x00.
  - Digit 1 gives 0x66.
  - Digit 0 gives 0x3F.
- Brightness: `bright`=3, SUB_DIV=2.
  - `an[idx]` is high for 7 of 32 clocks per slot: phases 0-3 minus the guard cycle.
- Tear-free latch: change `di` mid-frame from 16'h1111 to 16'h2222.
  - The displayed values stay 1 until after the next `frame` pulse.
- Direct mode: `direct`=1, `pixels`=32'h80FF0155.
  - `seg` per digit 0..3 is 0x55, 0x01, 0xFF, 0x80.
  - `dp` input has no effect.
- Reset mid-slot at digit 2:
  - `an`=0 and `seg`=0 the next cycle.
  - After release, `an[0]` asserts 2 cycles later.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seg7 scan driver: segment bit positions, the hex font
// and the brightness phase count.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam int PHASES  = 16;
  localparam int PHASE_W = 4;

  // Entry n is the gfedcba pattern for nibble n (0-9, A, b, C, d, E, F).
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_font.sv
// Combinational hex nibble to 7-segment (gfedcba, active-high) lookup.
module seg7_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed N-digit common-anode 7-segment scan driver with brightness PWM,
// leading-zero blanking and tear-free per-frame input latching.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int SUB_DIV = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   di,
  input  logic [8*DIGITS-1:0]   pixels,
  input  logic                  direct,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic [3:0]            bright,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int SUB_W = $clog2(SUB_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SUB_W-1:0]    sub_q, sub_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                load_pend_q, load_pend_d;

  logic [4*DIGITS-1:0] di_sh_q, di_sh_d;
  logic [8*DIGITS-1:0] pix_sh_q, pix_sh_d;
  logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic                direct_sh_q, direct_sh_d;
  logic                blz_sh_q, blz_sh_d;

  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic                sub_last, tick, idx_last, wrap, load;

  // NOTE: every signal driven from always_comb gets a default at the top of the
  // block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sub_d    = sub_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    sub_last = (sub_q == SUB_W'(SUB_DIV - 1));
    tick     = sub_last && (phase_q == PHASE_W'(PHASES - 1));
    idx_last = (idx_q == IDX_W'(DIGITS - 1));
    wrap     = tick && idx_last;
    if (sub_last) begin
      sub_d   = '0;
      phase_d = phase_q + 1'b1;
    end else begin
      sub_d = sub_q + 1'b1;
    end
    if (tick) begin
      idx_d = idx_last ? '0 : idx_q + 1'b1;
    end
  end

  // Inputs are captured once per frame (and right after reset) so a digit
  // never shows a half-updated word.
  always_comb begin
    load        = wrap || load_pend_q;
    load_pend_d = 1'b0;
    di_sh_d     = load ? di       : di_sh_q;
    pix_sh_d    = load ? pixels   : pix_sh_q;
    dp_sh_d     = load ? dp       : dp_sh_q;
    direct_sh_d = load ? direct   : direct_sh_q;
    blz_sh_d    = load ? blank_lz : blz_sh_q;
  end

  // On the load-pending cycle the shadows are still empty, so the guard cycle
  // shows the data being loaded instead.
  logic [4*DIGITS-1:0] src_di;
  logic [8*DIGITS-1:0] src_pix;
  logic [DIGITS-1:0]   src_dp;
  logic                src_direct, src_blz;

  assign src_di     = load_pend_q ? di       : di_sh_q;
  assign src_pix    = load_pend_q ? pixels   : pix_sh_q;
  assign src_dp     = load_pend_q ? dp       : dp_sh_q;
  assign src_direct = load_pend_q ? direct   : direct_sh_q;
  assign src_blz    = load_pend_q ? blank_lz : blz_sh_q;

  logic [3:0] nib;
  logic [7:0] pix;
  logic       dp_cur, blank_cur, all_zero;
  logic [6:0] font_seg;

  // Walk from the top digit down; all_zero means this nibble and all above are 0.
  always_comb begin
    nib       = '0;
    pix       = '0;
    dp_cur    = 1'b0;
    blank_cur = 1'b0;
    all_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (src_di[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        nib       = src_di[4*i +: 4];
        pix       = src_pix[8*i +: 8];
        dp_cur    = src_dp[i];
        blank_cur = src_blz && (i != 0) && all_zero;
      end
    end
  end

  seg7_font u_font (
    .nibble (nib),
    .seg    (font_seg)
  );

  logic lit;

  always_comb begin
    seg_d = '0;
    if (src_direct) begin
      seg_d = pix;
    end else begin
      seg_d[SEG_G:SEG_A] = blank_cur ? 7'h00 : font_seg;
      seg_d[SEG_DP]      = dp_cur;
    end
    lit = (phase_q <= bright) && !((phase_q == '0) && (sub_q == '0));
    an_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      an_d[i] = lit && (idx_q == IDX_W'(i));
    end
    frame_d = wrap;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_q       <= '0;
      phase_q     <= '0;
      idx_q       <= '0;
      load_pend_q <= 1'b1;
      di_sh_q     <= '0;
      pix_sh_q    <= '0;
      dp_sh_q     <= '0;
      direct_sh_q <= 1'b0;
      blz_sh_q    <= 1'b0;
      seg_q       <= '0;
      an_q        <= '0;
      frame_q     <= 1'b0;
    end else begin
      sub_q       <= sub_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      load_pend_q <= load_pend_d;
      di_sh_q     <= di_sh_d;
      pix_sh_q    <= pix_sh_d;
      dp_sh_q     <= dp_sh_d;
      direct_sh_q <= direct_sh_d;
      blz_sh_q    <= blz_sh_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: spec vector table, hand-written corner
// sequences and randomized traffic checked against a cycle-position model.
module tb_seg7_scan;

  localparam int DIGITS  = 4;
  localparam int SUB_DIV = 2;
  localparam int SLOT    = 16 * SUB_DIV;
  localparam int FRAME   = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] di = '0;
  logic [31:0] pixels = '0;
  logic        direct = 1'b0;
  logic [3:0]  dp = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  bright = 4'hF;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame;

  seg7_scan #(.DIGITS(DIGITS), .SUB_DIV(SUB_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .di       (di),
    .pixels   (pixels),
    .direct   (direct),
    .dp       (dp),
    .blank_lz (blank_lz),
    .bright   (bright),
    .seg      (seg),
    .an       (an),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int s_next   = 0;

  // Frame-latched copy of the inputs as the display should be using them.
  logic [15:0] m_di;
  logic [31:0] m_pix;
  logic [3:0]  m_dp;
  logic        m_direct, m_blz;

  logic [6:0] font_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [15:0] di;
    logic [31:0] pixels;
    logic [3:0]  dp;
    logic        direct;
    logic        blz;
    int          digit;
    logic [7:0]  exp_seg;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] ref_seg(input int d);
    logic [6:0] body;
    if (m_direct) return m_pix[8*d +: 8];
    body = font_ref[m_di[4*d +: 4]];
    if (m_blz && d > 0 && (m_di >> (4*d)) == 16'h0) body = 7'h00;
    return {m_dp[d], body};
  endfunction

  task automatic snapshot();
    m_di     = di;
    m_pix    = pixels;
    m_dp     = dp;
    m_direct = direct;
    m_blz    = blank_lz;
  endtask

  // One clock with the model: s is the scan position consumed by this edge.
  task automatic cycle();
    int s, dig, ph;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic       exp_frame;
    s = s_next;
    s_next++;
    if (s == 0) snapshot();
    dig       = (s / SLOT) % DIGITS;
    ph        = (s % SLOT) / SUB_DIV;
    exp_an    = (ph <= int'(bright) && (s % SLOT) != 0) ? 4'(1 << dig) : 4'b0000;
    exp_seg   = ref_seg(dig);
    exp_frame = ((s % FRAME) == FRAME - 1);
    if ((s % FRAME) == FRAME - 1) snapshot();
    @(posedge clk);
    #1;
    check("model_seg", 32'(seg), 32'(exp_seg));
    check("model_an", 32'(an), 32'(exp_an));
    check("model_frame", 32'(frame), 32'(exp_frame));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    check("reset_seg", 32'(seg), 32'h0);
    check("reset_an", 32'(an), 32'h0);
    check("reset_frame", 32'(frame), 32'h0);
    reset  = 1'b0;
    s_next = 0;
  endtask

  initial begin
    int cnt, waited;

    vecs[0]  = '{16'h12AF, 32'h0, 4'b0000, 1'b0, 1'b0, 0, 8'h71};
    vecs[1]  = '{16'h12AF, 32'h0, 4'b0000, 1'b0, 1'b0, 1, 8'h77};
    vecs[2]  = '{16'h12AF, 32'h0, 4'b0000, 1'b0, 1'b0, 2, 8'h5B};
    vecs[3]  = '{16'h12AF, 32'h0, 4'b0000, 1'b0, 1'b0, 3, 8'h06};
    vecs[4]  = '{16'h0040, 32'h0, 4'b1000, 1'b0, 1'b1, 3, 8'h80};
    vecs[5]  = '{16'h0040, 32'h0, 4'b1000, 1'b0, 1'b1, 2, 8'h00};
    vecs[6]  = '{16'h0040, 32'h0, 4'b1000, 1'b0, 1'b1, 1, 8'h66};
    vecs[7]  = '{16'h0040, 32'h0, 4'b1000, 1'b0, 1'b1, 0, 8'h3F};
    vecs[8]  = '{16'h0000, 32'h80FF0155, 4'b1111, 1'b1, 1'b1, 0, 8'h55};
    vecs[9]  = '{16'h0000, 32'h80FF0155, 4'b1111, 1'b1, 1'b1, 1, 8'h01};
    vecs[10] = '{16'h0000, 32'h80FF0155, 4'b1111, 1'b1, 1'b1, 2, 8'hFF};
    vecs[11] = '{16'h0000, 32'h80FF0155, 4'b1111, 1'b1, 1'b1, 3, 8'h80};

    // Spec vectors: show each listed digit mid-slot and compare with the table.
    for (int v = 0; v < 12; v++) begin
      di = vecs[v].di; pixels = vecs[v].pixels; dp = vecs[v].dp;
      direct = vecs[v].direct; blank_lz = vecs[v].blz; bright = 4'hF;
      do_reset(2);
      while (s_next <= vecs[v].digit * SLOT + 4) cycle();
      check($sformatf("vec%0d_seg", v), 32'(seg), 32'(vecs[v].exp_seg));
      check($sformatf("vec%0d_an", v), 32'(an), 32'(1 << vecs[v].digit));
    end

    // First lit output two clocks after reset release.
    di = 16'h12AF; direct = 1'b0; blank_lz = 1'b0; dp = '0; bright = 4'hF;
    do_reset(1);
    cycle();
    check("post_reset_guard_an", 32'(an), 32'h0);
    check("post_reset_guard_seg", 32'(seg), 32'h71);
    cycle();
    check("post_reset_lit_an", 32'(an), 32'h1);

    // Frame pulse spacing.
    waited = 0;
    while (frame !== 1'b1 && waited < 3 * FRAME) begin cycle(); waited++; end
    check("first_frame_seen", 32'(frame), 32'h1);
    cnt = 0;
    do begin cycle(); cnt++; end while (frame !== 1'b1 && cnt < 3 * FRAME);
    check("frame_period", 32'(cnt), 32'(FRAME));

    // Brightness: lit clocks per slot, including the minimum level.
    for (int b = 0; b < 2; b++) begin
      bright = (b == 0) ? 4'd3 : 4'd0;
      do_reset(1);
      while (s_next < SLOT) cycle();
      cnt = 0;
      for (int k = 0; k < SLOT; k++) begin
        cycle();
        if (an != 4'b0000) cnt++;
      end
      check($sformatf("bright%0d_lit_clocks", bright), 32'(cnt), (b == 0) ? 32'd7 : 32'd1);
    end
    bright = 4'hF;

    // Tear-free: a mid-frame change shows only after the next frame pulse.
    di = 16'h1111;
    do_reset(1);
    while (s_next < 2 * SLOT + 5) cycle();
    di = 16'h2222;
    while (s_next < 3 * SLOT + 5) cycle();
    check("tear_old_digit3", 32'(seg), 32'h06);
    while (s_next < FRAME + 5) cycle();
    check("tear_new_digit0", 32'(seg), 32'h5B);

    // Reset in the middle of digit 2's slot.
    di = 16'h12AF;
    do_reset(1);
    while (s_next < 2 * SLOT + 10) cycle();
    check("midreset_pre_an", 32'(an), 32'b0100);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_an", 32'(an), 32'h0);
    check("midreset_seg", 32'(seg), 32'h0);
    reset  = 1'b0;
    s_next = 0;
    cycle();
    check("midreset_release1_an", 32'(an), 32'h0);
    cycle();
    check("midreset_release2_an", 32'(an), 32'h1);

    // Randomized traffic with inputs changing at arbitrary points of the frame.
    for (int r = 0; r < 8; r++) begin
      di = 16'($urandom); pixels = $urandom; dp = 4'($urandom);
      direct = 1'($urandom); blank_lz = 1'($urandom); bright = 4'($urandom);
      if (r % 2 == 0) di = di & 16'h00FF;
      do_reset(1 + $urandom_range(0, 2));
      for (int k = 0; k < 2 * FRAME + 40; k++) begin
        if ($urandom_range(0, 29) == 0) begin
          di = 16'($urandom); pixels = $urandom; dp = 4'($urandom);
          direct = 1'($urandom); blank_lz = 1'($urandom);
          if ($urandom_range(0, 1) == 0) di = di & 16'h000F;
        end
        if ($urandom_range(0, 49) == 0) bright = 4'($urandom);
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
